// File: rtl/bmem_line_adapter_if.sv
// Bundle of the instruction port, data port and burst-memory signals of the line adapter.
// The adapter takes the slave view; requesters and the memory model take the master view.
interface bmem_line_adapter_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic [31:0]       i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [31:0]       d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [31:0]       bmem_address;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_resp;

  modport slave (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, bmem_rdata, bmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, bmem_address, bmem_read, bmem_write, bmem_wdata
  );

  modport master (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata, bmem_rdata, bmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, bmem_address, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/bmem_line_adapter.sv
// Arbitrates instruction and data line requests onto a burst memory, splitting
// lines into BEATS beats on write and assembling beats into a line on read.
module bmem_line_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  bmem_line_adapter_if.slave bus
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_BEAT,
    WR_BEAT,
    WR_WAIT,
    DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_d;
  logic              r_grant_d;
  logic [31:0]       r_addr;
  logic [LINE_W-1:0] r_wline;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              r_i_resp;
  logic              r_d_resp;
  logic              r_bmem_read;
  logic              r_bmem_write;
  logic [BEAT_W-1:0] r_bmem_wdata;

  logic              w_i_req;
  logic              w_d_req;
  logic              w_grant_d;
  logic [31:0]       w_req_addr;
  logic              w_last;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [BEAT_W-1:0] w_wbeat [BEATS];
  logic [LINE_W-1:0] w_line_next;

  assign w_i_req    = bus.i_read;
  assign w_d_req    = bus.d_read | bus.d_write;
  // On a tie the port that lost last time wins; r_last_d=0 means I was last.
  assign w_grant_d  = w_d_req & (~w_i_req | ~r_last_d);
  assign w_req_addr = w_grant_d ? bus.d_addr : bus.i_addr;
  assign w_last     = (r_cnt == CNT_W'(BEATS - 1));
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign w_wbeat[gi] = r_wline[gi*BEAT_W +: BEAT_W];
      assign w_line_next[gi*BEAT_W +: BEAT_W] =
        (r_cnt == CNT_W'(gi)) ? bus.bmem_rdata : r_line[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_d     <= 1'b0;
      r_grant_d    <= 1'b0;
      r_addr       <= '0;
      r_wline      <= '0;
      r_line       <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_resp     <= 1'b0;
      r_d_resp     <= 1'b0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_bmem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_i_req || w_d_req) begin
            r_last_d  <= w_grant_d;
            r_grant_d <= w_grant_d;
            r_cnt     <= '0;
            r_addr    <= {w_req_addr[31:5], 5'b0};
            // A data request with both read and write high is a writeback.
            if (w_grant_d && bus.d_write) begin
              r_wline      <= bus.d_wdata;
              r_bmem_write <= 1'b1;
              r_bmem_wdata <= bus.d_wdata[BEAT_W-1:0];
              r_state      <= WR_BEAT;
            end else begin
              r_bmem_read <= 1'b1;
              r_state     <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          r_bmem_read <= 1'b0;
          r_state     <= RD_BEAT;
        end
        RD_BEAT: begin
          if (bus.bmem_resp) begin
            r_line <= w_line_next;
            r_cnt  <= w_cnt_inc;
            if (w_last) begin
              r_state <= DONE;
              if (r_grant_d) begin
                r_d_rdata <= w_line_next;
                r_d_resp  <= 1'b1;
              end else begin
                r_i_rdata <= w_line_next;
                r_i_resp  <= 1'b1;
              end
            end
          end
        end
        WR_BEAT: begin
          if (!w_last) begin
            r_cnt        <= w_cnt_inc;
            r_bmem_wdata <= w_wbeat[w_cnt_inc];
          end else begin
            r_bmem_write <= 1'b0;
            r_bmem_wdata <= '0;
            // An acknowledge coinciding with the final beat completes immediately.
            if (bus.bmem_resp) begin
              r_d_resp <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state <= WR_WAIT;
            end
          end
        end
        WR_WAIT: begin
          if (bus.bmem_resp) begin
            r_d_resp <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_i_resp <= 1'b0;
          r_d_resp <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bmem_address = r_addr;
  assign bus.bmem_read    = r_bmem_read;
  assign bus.bmem_write   = r_bmem_write;
  assign bus.bmem_wdata   = r_bmem_wdata;
  assign bus.i_rdata      = r_i_rdata;
  assign bus.i_resp       = r_i_resp;
  assign bus.d_rdata      = r_d_rdata;
  assign bus.d_resp       = r_d_resp;
endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed bench for bmem_line_adapter: expected lines and write beats are queued
// when a request is issued and compared when the adapter responds.
module tb_bmem_line_adapter;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bmem_line_adapter_if #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();

  bmem_line_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [LINE_W-1:0] rd_q [$];
  logic [BEAT_W-1:0] wr_q [$];
  logic [LINE_W-1:0] last_d_line;
  logic [LINE_W-1:0] last_i_line;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"},   bus.bmem_address, 0);
    chk({tag, "_read"},   bus.bmem_read, 0);
    chk({tag, "_write"},  bus.bmem_write, 0);
    chk({tag, "_wdata"},  bus.bmem_wdata, 0);
    chk({tag, "_irdata"}, bus.i_rdata, 0);
    chk({tag, "_iresp"},  bus.i_resp, 0);
    chk({tag, "_drdata"}, bus.d_rdata, 0);
    chk({tag, "_dresp"},  bus.d_resp, 0);
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic issue_read(input bit port_d, input logic [31:0] addr, input logic [LINE_W-1:0] line);
    if (port_d) begin
      bus.d_addr = addr;
      bus.d_read = 1'b1;
    end else begin
      bus.i_addr = addr;
      bus.i_read = 1'b1;
    end
    rd_q.push_back(line);
  endtask

  task automatic serve_read(input bit port_d, input logic [31:0] addr, input logic [LINE_W-1:0] line, input int gap);
    int t;
    t = 0;
    while (bus.bmem_read !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk("rd_strobe", bus.bmem_read, 1);
    chk("rd_addr", bus.bmem_address, {addr[31:5], 5'b0});
    tick();
    chk("rd_strobe_1cyc", bus.bmem_read, 0);
    for (int k = 0; k < BEATS; k++) begin
      repeat (gap) begin
        bus.bmem_resp = 1'b0;
        tick();
        chk("rd_gap_no_resp", bus.i_resp | bus.d_resp, 0);
      end
      bus.bmem_resp  = 1'b1;
      bus.bmem_rdata = line[k*BEAT_W +: BEAT_W];
      tick();
      if (k < BEATS - 1) chk("rd_no_early_resp", bus.i_resp | bus.d_resp, 0);
    end
    bus.bmem_resp = 1'b0;
    if (port_d) begin
      chk("d_resp", bus.d_resp, 1);
      chk("d_resp_i_quiet", bus.i_resp, 0);
      chk("d_rdata", bus.d_rdata, rd_q.pop_front());
      bus.d_read  = 1'b0;
      last_d_line = line;
    end else begin
      chk("i_resp", bus.i_resp, 1);
      chk("i_resp_d_quiet", bus.d_resp, 0);
      chk("i_rdata", bus.i_rdata, rd_q.pop_front());
      bus.i_read  = 1'b0;
      last_i_line = line;
    end
    $display("txn read  port=%s addr=%08h line=%064h", port_d ? "D" : "I", addr, line);
    tick();
    chk("rd_resp_pulse", bus.i_resp | bus.d_resp, 0);
  endtask

  task automatic serve_write(input logic [31:0] addr, input logic [LINE_W-1:0] wdata, input bit ack_last, input bit also_read);
    int t;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_write = 1'b1;
    bus.d_read  = also_read;
    for (int k = 0; k < BEATS; k++) wr_q.push_back(wdata[k*BEAT_W +: BEAT_W]);
    t = 0;
    while (bus.bmem_write !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk("wr_addr", bus.bmem_address, {addr[31:5], 5'b0});
    chk("wr_no_read", bus.bmem_read, 0);
    for (int k = 0; k < BEATS; k++) begin
      chk("wr_strobe", bus.bmem_write, 1);
      chk("wr_beat", bus.bmem_wdata, wr_q.pop_front());
      // In ack_last mode a stray resp on beat 0 must be ignored.
      bus.bmem_resp = ack_last && (k == 0 || k == BEATS - 1);
      tick();
      bus.bmem_resp = 1'b0;
      if (k < BEATS - 1) chk("wr_no_early_resp", bus.d_resp, 0);
    end
    chk("wr_strobe_end", bus.bmem_write, 0);
    if (!ack_last) begin
      repeat (3) begin
        chk("wr_wait_no_resp", bus.d_resp, 0);
        chk("wr_wait_no_strobe", bus.bmem_write, 0);
        tick();
      end
      bus.bmem_resp = 1'b1;
      tick();
      bus.bmem_resp = 1'b0;
    end
    chk("wr_d_resp", bus.d_resp, 1);
    chk("wr_i_quiet", bus.i_resp, 0);
    bus.d_write = 1'b0;
    bus.d_read  = 1'b0;
    $display("txn write port=D addr=%08h line=%064h ack_last=%0d", addr, wdata, ack_last);
    tick();
    chk("wr_resp_pulse", bus.d_resp, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LINE_W-1:0] l_a, l_b, l_c, l_d, l_w;
    int t;
    rst             = 1'b1;
    bus.i_addr      = '0;
    bus.i_read      = 1'b0;
    bus.d_addr      = '0;
    bus.d_read      = 1'b0;
    bus.d_write     = 1'b0;
    bus.d_wdata     = '0;
    bus.bmem_rdata  = '0;
    bus.bmem_resp   = 1'b0;
    last_d_line     = '0;
    last_i_line     = '0;
    repeat (2) tick();
    chk_zero("reset");
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("idle_read", bus.bmem_read, 0);
      chk("idle_write", bus.bmem_write, 0);
    end

    // Tie right after reset: D first, then I; the repeated tie goes to D again.
    l_a = rand_line();
    l_b = rand_line();
    issue_read(1'b1, 32'h1000_0100, l_a);
    issue_read(1'b0, 32'h2000_0200, l_b);
    serve_read(1'b1, 32'h1000_0100, l_a, 0);
    serve_read(1'b0, 32'h2000_0200, l_b, 0);
    l_a = rand_line();
    l_b = rand_line();
    issue_read(1'b1, 32'h1000_013F, l_a);
    issue_read(1'b0, 32'h2000_0251, l_b);
    serve_read(1'b1, 32'h1000_013F, l_a, 0);
    serve_read(1'b0, 32'h2000_0251, l_b, 0);
    chk("d_rdata_held", bus.d_rdata, last_d_line);

    l_c = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    issue_read(1'b0, 32'h6000_0024, l_c);
    serve_read(1'b0, 32'h6000_0024, l_c, 0);

    l_w = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    serve_write(32'h6000_0040, l_w, 1'b0, 1'b0);
    serve_write(32'h6000_009C, rand_line(), 1'b1, 1'b1);
    chk("d_rdata_after_write", bus.d_rdata, last_d_line);
    chk("i_rdata_after_write", bus.i_rdata, last_i_line);

    l_d = rand_line();
    issue_read(1'b0, 32'h3000_0010, l_d);
    serve_read(1'b0, 32'h3000_0010, l_d, 2);
    l_d = rand_line();
    issue_read(1'b1, 32'h3000_0F00, l_d);
    serve_read(1'b1, 32'h3000_0F00, l_d, 1);

    // Reset in the middle of a read after two beats have been captured.
    l_d = rand_line();
    bus.i_addr = 32'h4000_0000;
    bus.i_read = 1'b1;
    t = 0;
    while (bus.bmem_read !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk("rst_rd_strobe", bus.bmem_read, 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      bus.bmem_resp  = 1'b1;
      bus.bmem_rdata = l_d[k*BEAT_W +: BEAT_W];
      tick();
    end
    bus.bmem_resp = 1'b0;
    rst = 1'b1;
    bus.i_read = 1'b0;
    #1;
    chk_zero("rst_mid");
    tick();
    rst = 1'b0;
    for (int k = 2; k < BEATS; k++) begin
      bus.bmem_resp  = 1'b1;
      bus.bmem_rdata = l_d[k*BEAT_W +: BEAT_W];
      tick();
      chk("rst_late_beat_iresp", bus.i_resp, 0);
      chk("rst_late_beat_read", bus.bmem_read, 0);
    end
    bus.bmem_resp = 1'b0;
    tick();
    chk("rst_after_irdata", bus.i_rdata, 0);
    $display("txn abort port=I addr=40000000");

    l_d = rand_line();
    issue_read(1'b0, 32'h4000_0000, l_d);
    serve_read(1'b0, 32'h4000_0000, l_d, 0);

    chk("rd_q_drained", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bmem_line_adapter.md
BMEM_LINE_ADAPTER -- requirements
Module: bmem_line_adapter

Interface
REQ-001 Parameter: LINE_W, default 256, cache-line width in bits.
REQ-002 Parameter: BEAT_W, default 64, burst-memory beat width in bits; BEATS = LINE_W/BEAT_W, 4 at defaults.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: i_addr  input  32  instruction-port line address.
REQ-006 Port: i_read  input  1  instruction-port read request, level, held until i_resp.
REQ-007 Port: i_rdata  output  LINE_W  instruction-port returned line.
REQ-008 Port: i_resp  output  1  instruction-port completion pulse.
REQ-009 Port: d_addr  input  32  data-port line address.
REQ-010 Port: d_read / d_write  input  1 each  data-port read / writeback request, level, held until d_resp.
REQ-011 Port: d_wdata  input  LINE_W  data-port writeback line.
REQ-012 Port: d_rdata  output  LINE_W  data-port returned line.
REQ-013 Port: d_resp  output  1  data-port completion pulse.
REQ-014 Port: bmem_address  output  32  burst-memory address.
REQ-015 Port: bmem_read / bmem_write  output  1 each  burst-memory read / write strobes.
REQ-016 Port: bmem_wdata  output  BEAT_W  write beat.
REQ-017 Port: bmem_rdata  input  BEAT_W  read beat, valid when bmem_resp=1.
REQ-018 Port: bmem_resp  input  1  burst-memory beat or write acknowledge.

Function
REQ-019 FSM states SHALL be IDLE, RD_REQ, RD_BEAT, WR_BEAT, WR_WAIT, DONE.
REQ-020 IDLE: with no request pending, SHALL stay in IDLE and drive bmem_read=bmem_write=0.
REQ-021 Arbitration in IDLE: single pending port is granted; both pending -> grant the port not granted last; last-grant register resets to I, so the first tie goes to D.
REQ-022 Granted D with d_read and d_write both high SHALL be treated as a write.
REQ-023 On grant, address latched with bits[4:0] forced to 0; bmem_address SHALL hold it for the entire transaction.
REQ-024 Read: RD_REQ lasts exactly one cycle with bmem_read=1, then RD_BEAT.
REQ-025 RD_BEAT: each cycle with bmem_resp=1 stores bmem_rdata into beat slot k (k=0..BEATS-1, beat 0 -> bits[BEAT_W-1:0]) and increments k; gaps between beats are allowed.
REQ-026 After beat BEATS-1 is captured, next state SHALL be DONE.
REQ-027 Write: WR_BEAT SHALL assert bmem_write for exactly BEATS consecutive cycles, bmem_wdata = beat k of the latched d_wdata in cycle k, lowest beat first.
REQ-028 After the last write beat, go to WR_WAIT until bmem_resp=1, then DONE; bmem_resp=1 during the last write beat SHALL go directly to DONE.
REQ-029 bmem_resp seen in IDLE, RD_REQ, DONE or non-final WR_BEAT cycles SHALL be ignored.
REQ-030 DONE lasts one cycle: granted port's resp=1; for reads, its rdata holds the assembled line; then IDLE.
REQ-031 i_rdata/d_rdata SHALL hold the last returned line until the next read completes on that port.
REQ-032 Latency: read resp exactly 1 cycle after the last beat; write resp exactly 1 cycle after the acknowledge.
REQ-033 Beat counter width SHALL be clog2(BEATS); it clears on every grant.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, beat count 0, last-grant=I, and drive all outputs to 0: bmem_address, bmem_read, bmem_write, bmem_wdata, i_rdata, i_resp, d_rdata, d_resp.
REQ-035 Reset mid-transaction SHALL abandon it with no resp; beats arriving afterward are ignored per REQ-029.

Verification
REQ-036 Read, i_addr=0x6000_0024, beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles -> bmem_address=0x6000_0020, one bmem_read cycle, i_resp one cycle after beat 3, i_rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-037 Write, d_addr=0x6000_0040, d_wdata=256'hDDDD...AAAA -> 4 bmem_write cycles with wdata beats A,B,C,D, then ack after 3 idle cycles -> d_resp exactly one cycle after ack.
REQ-038 i_read and d_read raised in the same cycle after reset -> D served first, then I; repeat the tie -> D first again since I was last granted.
REQ-039 Read with 2-cycle gaps between beats -> rdata correct; no early resp.
REQ-040 rst pulse during RD_BEAT after beat 1 -> all outputs 0 at once, no resp; later beats ignored; next request completes normally.
